// File: rtl/axi_dma_pkg.sv
// Shared AXI encodings, page constants and FSM states
// for the DMA read path.
package axi_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_MOD  = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEF   = 3'b000;

  localparam int unsigned PAGE_BYTES = 4096;
  localparam int unsigned PAGE_BITS  = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R
  } state_e;

endpackage

// File: rtl/axi_burst_splitter.sv
// Burst sizing: clips a burst to the remaining beats,
// the max burst length and the next 4 KB page.
module axi_burst_splitter
  import axi_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [LEN_WIDTH-1:0]  remaining,
  output logic [8:0]            beats,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [LEN_WIDTH-1:0]  next_remaining
);

  localparam int SZ = $clog2(DATA_WIDTH / 8);
  localparam int CW = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [CW-1:0] rem_w;
  logic [CW-1:0] page_w;
  logic [CW-1:0] max_w;
  logic [CW-1:0] min_w;
  logic [12:0]   page_left;

  // min of remaining, max burst and beats left in page
  always_comb begin
    page_left = 13'(PAGE_BYTES)
              - {1'b0, addr[PAGE_BITS-1:0]};
    rem_w  = CW'(remaining);
    page_w = CW'(page_left >> SZ);
    max_w  = CW'(MAX_BURST);
    min_w  = rem_w;
    if (page_w < min_w) min_w = page_w;
    if (max_w < min_w)  min_w = max_w;
    beats  = 9'(min_w);
    next_addr = addr
              + (ADDR_WIDTH'(beats) << SZ);
    next_remaining = remaining
                   - LEN_WIDTH'(beats);
  end

endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read initiator: splits a command into INCR bursts
// and forwards R beats straight onto an AXI-Stream.
module axi_burst_reader
  import axi_dma_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_beats,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  done,
  output logic                  err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ADDR_WIDTH'(BYTES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [8:0]            beats_q, beats_d;
  logic [8:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic [8:0]            sp_beats;
  logic [ADDR_WIDTH-1:0] sp_addr;
  logic [LEN_WIDTH-1:0]  sp_rem;
  logic                  in_r;
  logic                  r_fire;
  logic                  beat_last;

  axi_burst_splitter #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_BURST (MAX_BURST),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_split (
    .addr          (addr_q),
    .remaining     (rem_q),
    .beats         (sp_beats),
    .next_addr     (sp_addr),
    .next_remaining(sp_rem)
  );

  assign in_r      = (state_q == ST_R);
  assign r_fire    = m_axi_rvalid & m_axi_rready;
  assign beat_last = (cnt_q == beats_q - 9'd1);

  // state and datapath registers
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // command accept, burst issue and beat tracking
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr & ~ALIGN_MASK;
          rem_d  = cmd_beats;
          err_d  = 1'b0;
          if (cmd_beats == '0) done_d = 1'b1;
          else state_d = ST_AR;
        end
      end
      ST_AR: begin
        if (m_axi_arready) begin
          state_d = ST_R;
          addr_d  = sp_addr;
          rem_d   = sp_rem;
          beats_d = sp_beats;
          cnt_d   = '0;
        end
      end
      ST_R: begin
        if (r_fire) begin
          cnt_d = cnt_q + 9'd1;
          if (m_axi_rresp != 2'b00 ||
              m_axi_rlast != beat_last)
            err_d = 1'b1;
          if (beat_last)
            state_d = (rem_q == '0) ? ST_IDLE : ST_AR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // AR payload and zero-latency R to stream passthrough
  always_comb begin
    cmd_ready     = (state_q == ST_IDLE);
    m_axi_arvalid = (state_q == ST_AR);
    m_axi_araddr  = addr_q;
    m_axi_arlen   = (state_q == ST_AR)
                  ? 8'(sp_beats - 9'd1) : 8'd0;
    m_axi_arsize  = 3'(SZ);
    m_axi_arburst = AXI_BURST_INCR;
    m_axi_arcache = AXI_CACHE_MOD;
    m_axi_arprot  = AXI_PROT_DEF;
    m_axi_rready  = m_axis_tready & in_r;
    m_axis_tvalid = m_axi_rvalid & in_r;
    m_axis_tdata  = m_axi_rdata;
    m_axis_tlast  = in_r & beat_last & (rem_q == '0);
    done          = done_q
                  | (in_r & r_fire & beat_last
                     & (rem_q == '0));
    err           = err_q;
  end

endmodule

// File: tb/tb_axi_burst_reader.sv
// Bench for axi_burst_reader: memory responder, stream and
// AR scoreboards, vector table plus reset corner sequence.
module tb_axi_burst_reader;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] beats;
    int          delay;
    bit          tog;
    logic [31:0] bad;
    bit          err;
    int          nar;
    ar_t [2:0]   ars;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [63:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int ar_cnt = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int rd_delay = 0;
  bit tog = 1'b0;
  logic [31:0] bad_addr = 32'hDEAD_BEEF;

  ar_t         exp_ar_q[$];
  logic [63:0] exp_d_q[$];
  logic        exp_l_q[$];
  vec_t        vt[7];

  always #5 clk = ~clk;

  axi_burst_reader #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(32),
    .MAX_BURST (16),
    .LEN_WIDTH (16)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_beats    (cmd_beats),
    .m_axi_araddr (araddr),
    .m_axi_arlen  (arlen),
    .m_axi_arsize (arsize),
    .m_axi_arburst(arburst),
    .m_axi_arcache(arcache),
    .m_axi_arprot (arprot),
    .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata  (rdata),
    .m_axi_rresp  (rresp),
    .m_axi_rlast  (rlast),
    .m_axi_rvalid (rvalid),
    .m_axi_rready (rready),
    .m_axis_tdata (tdata),
    .m_axis_tlast (tlast),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .done         (done),
    .err          (err)
  );

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, a};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [31:0] addr, input logic [15:0] beats,
    input int delay, input bit tg, input logic [31:0] bad,
    input bit e, input int nar,
    input logic [31:0] a0, input logic [7:0] l0,
    input logic [31:0] a1, input logic [7:0] l1,
    input logic [31:0] a2, input logic [7:0] l2);
    vec_t v;
    v.addr = addr;  v.beats = beats;
    v.delay = delay; v.tog = tg;
    v.bad = bad; v.err = e; v.nar = nar;
    v.ars[0] = '{addr: a0, len: l0};
    v.ars[1] = '{addr: a1, len: l1};
    v.ars[2] = '{addr: a2, len: l2};
    return v;
  endfunction

  // backpressure on stream and AR ready
  initial begin
    tready = 1'b1;
    arready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tog) begin
        tready = ~tready;
        arready = ~arready;
      end else begin
        tready = 1'b1;
        arready = 1'b1;
      end
    end
  end

  // memory responder: one burst at a time
  initial begin
    rvalid = 1'b0;
    rdata = '0;
    rresp = 2'b00;
    rlast = 1'b0;
    forever begin : resp_blk
      logic [31:0] a;
      int n;
      bit abort;
      bit ok;
      @(negedge clk);
      if (!rst && arvalid && arready) begin
        a = araddr;
        n = int'(arlen) + 1;
        abort = 1'b0;
        @(posedge clk);
        repeat (rd_delay) @(posedge clk);
        #1;
        for (int i = 0; i < n && !abort; i++) begin
          rvalid = 1'b1;
          rdata = pat(a + 32'(i * 8));
          rlast = (i == n - 1);
          rresp = ((a + 32'(i * 8)) == bad_addr)
                ? 2'b10 : 2'b00;
          forever begin
            @(negedge clk);
            if (rst) begin
              abort = 1'b1;
              break;
            end
            ok = rready;
            @(posedge clk);
            #1;
            if (ok) break;
          end
        end
        rvalid = 1'b0;
        rlast = 1'b0;
        rresp = 2'b00;
      end
    end
  end

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (arvalid && arready) begin
        ar_cnt++;
        if (exp_ar_q.size() == 0) begin
          chk("ar_extra", 64'(araddr), 64'hFFFF_FFFF_FFFF);
        end else begin
          ar_t e;
          e = exp_ar_q.pop_front();
          chk("araddr", 64'(araddr), 64'(e.addr));
          chk("arlen", 64'(arlen), 64'(e.len));
          chk("ar_const",
              64'({arsize, arburst, arcache, arprot}),
              64'({3'd3, 2'b01, 4'b0011, 3'b000}));
        end
      end
      if (tvalid) chk("rready_track", 64'(rready), 64'(tready));
      if (tvalid && tready) begin
        beat_cnt++;
        if (exp_d_q.size() == 0) begin
          chk("beat_extra", tdata, 64'hDEAD);
        end else begin
          chk("tdata", tdata, exp_d_q.pop_front());
          chk("tlast", 64'(tlast), 64'(exp_l_q.pop_front()));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] base;
    int d0;
    int a0;
    int t;
    base = v.addr & ~32'h7;
    rd_delay = v.delay;
    tog = v.tog;
    bad_addr = v.bad;
    for (int i = 0; i < int'(v.beats); i++) begin
      exp_d_q.push_back(pat(base + 32'(i * 8)));
      exp_l_q.push_back(i == int'(v.beats) - 1);
    end
    for (int i = 0; i < v.nar; i++) exp_ar_q.push_back(v.ars[i]);
    d0 = done_cnt;
    a0 = ar_cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = v.addr;
    cmd_beats = v.beats;
    @(negedge clk);
    chk($sformatf("v%0d_cmd_ready", idx), 64'(cmd_ready), 64'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_err_clr", idx), 64'(err), 64'd0);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk($sformatf("v%0d_done_cnt", idx), 64'(done_cnt - d0), 64'd1);
    chk($sformatf("v%0d_ar_cnt", idx), 64'(ar_cnt - a0), 64'(v.nar));
    chk($sformatf("v%0d_left", idx), 64'(exp_d_q.size()), 64'd0);
    chk($sformatf("v%0d_err", idx), 64'(err), 64'(v.err));
    tog = 1'b0;
    exp_d_q.delete();
    exp_l_q.delete();
    exp_ar_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int a0;
    int b0;
    int t;
    vt[0] = mk(32'h0, 16'd4, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1,
               32'h0, 8'd3, 32'h0, 8'd0, 32'h0, 8'd0);
    vt[1] = mk(32'h0, 16'd40, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 3,
               32'h0, 8'd15, 32'h80, 8'd15, 32'h100, 8'd7);
    vt[2] = mk(32'hFE0, 16'd8, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2,
               32'hFE0, 8'd3, 32'h1000, 8'd3, 32'h0, 8'd0);
    vt[3] = mk(32'h200, 16'd12, 10, 1'b1, 32'hDEAD_BEEF, 1'b0, 1,
               32'h200, 8'd11, 32'h0, 8'd0, 32'h0, 8'd0);
    vt[4] = mk(32'h300, 16'd4, 0, 1'b0, 32'h308, 1'b1, 1,
               32'h300, 8'd3, 32'h0, 8'd0, 32'h0, 8'd0);
    vt[5] = mk(32'h407, 16'd3, 2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1,
               32'h400, 8'd2, 32'h0, 8'd0, 32'h0, 8'd0);
    vt[6] = mk(32'hFFFF_FFF0, 16'd4, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 2,
               32'hFFFF_FFF0, 8'd1, 32'h0, 8'd1, 32'h0, 8'd0);

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_beats = '0;
    #12;
    chk("rst_outs",
        64'({arvalid, rready, tvalid, tlast, done, err}), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_arlen", 64'(arlen), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // reset in the middle of an R burst
    rd_delay = 0;
    tog = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_d_q.push_back(pat(32'h500 + 32'(i * 8)));
      exp_l_q.push_back(i == 7);
    end
    exp_ar_q.push_back('{addr: 32'h500, len: 8'd7});
    b0 = beat_cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = 32'h500;
    cmd_beats = 16'd8;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    t = 0;
    while (beat_cnt < b0 + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("mid_beats", 64'(beat_cnt - b0 >= 2), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_outs",
        64'({arvalid, rready, tvalid, done}), 64'd0);
    exp_d_q.delete();
    exp_l_q.delete();
    exp_ar_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);

    // zero-beat command after the reset
    a0 = ar_cnt;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = 32'h40;
    cmd_beats = 16'd0;
    @(negedge clk);
    chk("zero_pre_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_idle", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    chk("zero_done_off", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_no_ar", 64'(ar_cnt - a0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
